// File: rtl/ball_frame_scheduler.sv
// Ball state holder: staged writes, vsync-aligned commit, frame counter,
// and registered per-pixel ball hit test feeding the color mapper.
module ball_frame_scheduler #(
  parameter  int NUM_BALLS = 4,
  parameter  int COORD_W   = 10,
  parameter  int RAD_W     = 6,
  localparam int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               VGA_VS,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [RAD_W-1:0]   wr_r,
  output logic               wr_ready,
  input  logic               commit,
  output logic               commit_pending,
  output logic               commit_done,
  output logic [15:0]        frame_count,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               is_ball,
  output logic [IDX_W-1:0]   ballID
);

  localparam int SQ_W = 2*COORD_W+2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [RAD_W-1:0]   r;
  } ball_t;

  typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               again_q, again_d;
  logic               vs_q;
  logic [15:0]        frame_count_q, frame_count_d;
  ball_t              stg_q [NUM_BALLS];
  ball_t              stg_d [NUM_BALLS];
  ball_t              act_q [NUM_BALLS];
  ball_t              act_d [NUM_BALLS];
  logic               wr_ready_q, wr_ready_d;
  logic               commit_pending_q, commit_pending_d;
  logic               commit_done_q, commit_done_d;
  logic               is_ball_q, is_ball_d;
  logic [IDX_W-1:0]   ball_id_q, ball_id_d;
  logic               vs_fall;

  logic signed [COORD_W:0] dx, dy;
  logic signed [SQ_W-1:0]  dxe, dye;
  logic [SQ_W-1:0]         d2, r2;

  assign vs_fall = vs_q & ~VGA_VS;

  always_comb begin
    frame_count_d = frame_count_q + 16'(vs_fall);
    stg_d         = stg_q;
    act_d         = act_q;
    state_d       = state_q;
    idx_d         = idx_q;
    again_d       = again_q;
    if (wr_en && wr_ready_q && (32'(wr_idx) < NUM_BALLS))
      stg_d[wr_idx] = '{x: wr_x, y: wr_y, r: wr_r};
    unique case (state_q)
      IDLE: begin
        if (commit) state_d = ARMED;
      end
      ARMED: begin
        if (vs_fall) begin
          state_d = COPY;
          idx_d   = '0;
        end
      end
      COPY: begin
        act_d[idx_q] = stg_q[idx_q];
        idx_d        = idx_q + 1'b1;
        if (commit) again_d = 1'b1;
        if (32'(idx_q) == NUM_BALLS-1) state_d = DONE;
      end
      DONE: begin
        state_d = (again_q || commit) ? ARMED : IDLE;
        again_d = 1'b0;
      end
    endcase
    wr_ready_d       = (state_d != COPY);
    commit_pending_d = (state_d != IDLE);
    commit_done_d    = (state_d == DONE);
  end

  // Descending scan so the lowest enabled index wins on overlap
  always_comb begin
    is_ball_d = 1'b0;
    ball_id_d = '0;
    dx = '0;
    dy = '0;
    dxe = '0;
    dye = '0;
    d2 = '0;
    r2 = '0;
    for (int i = NUM_BALLS-1; i >= 0; i--) begin
      dx  = $signed({1'b0, DrawX}) - $signed({1'b0, act_q[i].x});
      dy  = $signed({1'b0, DrawY}) - $signed({1'b0, act_q[i].y});
      dxe = {{(COORD_W+1){dx[COORD_W]}}, dx};
      dye = {{(COORD_W+1){dy[COORD_W]}}, dy};
      d2  = dxe*dxe + dye*dye;
      r2  = '0;
      r2[2*RAD_W-1:0] = act_q[i].r * act_q[i].r;
      if ((act_q[i].r != '0) && (d2 <= r2)) begin
        is_ball_d = 1'b1;
        ball_id_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      again_q          <= 1'b0;
      vs_q             <= 1'b1;
      frame_count_q    <= '0;
      stg_q            <= '{default: '0};
      act_q            <= '{default: '0};
      wr_ready_q       <= 1'b1;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      is_ball_q        <= 1'b0;
      ball_id_q        <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      again_q          <= again_d;
      vs_q             <= VGA_VS;
      frame_count_q    <= frame_count_d;
      stg_q            <= stg_d;
      act_q            <= act_d;
      wr_ready_q       <= wr_ready_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      is_ball_q        <= is_ball_d;
      ball_id_q        <= ball_id_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;
  assign frame_count    = frame_count_q;
  assign is_ball        = is_ball_q;
  assign ballID         = ball_id_q;

endmodule
